obi_wb_arbiter: RTL

- Shares one Wishbone-style master bus between the core's OBI-style instruction port and data port.
- Used in processorci_top variants where the Controller exposes a single memory bus.
- Accepts one transaction at a time with strict request → grant → bus → response sequencing.
- Round-robin or fixed data-priority arbitration; optional bus-timeout error.

---
 rtl/obi_wb_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/obi_wb_arbiter.sv
// obi_wb_arbiter
//   Shares one Wishbone-style master bus between the core's OBI instruction
//   and data ports. One transaction is in flight at a time:
//   request/grant (IDLE) -> bus cycle (BUS) -> one-cycle response (RESP).
//   Contention is resolved round-robin (ROUND_ROBIN=1) or with the data
//   port always winning (ROUND_ROBIN=0).
//
//   Optional feature, macro ARB_TIMEOUT_EN: a bus cycle that sees no ack for
//   TIMEOUT_CYCLES cycles is aborted and answered with err=1, rdata=0.
//   With the macro undefined the bus waits for ack indefinitely and both err
//   outputs stay 0.
//
// Ports
//   clk_core, rst_core          clock, synchronous active-high reset
//   instr_*                     OBI instruction port (read only)
//   data_*                      OBI data port (read/write, byte enables)
//   core_cyc/stb/we/wstrb/addr/data_out   Wishbone master outputs
//   core_data_in, core_ack      Wishbone slave response
module obi_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic                    instr_err_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_wstrb,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

  state_t state, state_nxt;
  owner_t owner, last_owner, winner;
  logic   grant;
  logic   bus_timeout;
  logic   bus_done;

  // The timeout counter must fit in 16 bits.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("obi_wb_arbiter: TIMEOUT_CYCLES out of range");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0] to_cnt;

  // to_cnt counts completed ack-less BUS cycles; the abort fires at the end
  // of the TIMEOUT_CYCLES-th one. An ack in that same cycle takes priority.
  assign bus_timeout = (state == BUS) && !core_ack &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_core) begin
    if (rst_core || state != BUS) begin
      to_cnt <= '0;
    end else if (!core_ack) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign bus_timeout = 1'b0;
`endif

  assign bus_done = (state == BUS) && (core_ack || bus_timeout);
  assign core_stb = core_cyc;

  // Arbitration, grant and next state
  always_comb begin
    winner    = OWN_INSTR;
    state_nxt = state;
    if (instr_req_i && data_req_i) begin
      if (ROUND_ROBIN != 0 && last_owner == OWN_DATA) begin
        winner = OWN_INSTR;
      end else begin
        winner = OWN_DATA;
      end
    end else if (data_req_i) begin
      winner = OWN_DATA;
    end
    grant       = (state == IDLE) && (instr_req_i || data_req_i);
    instr_gnt_o = grant && (winner == OWN_INSTR);
    data_gnt_o  = grant && (winner == OWN_DATA);
    case (state)
      IDLE:    if (grant) state_nxt = BUS;
      BUS:     if (bus_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus outputs and response registers
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      owner          <= OWN_INSTR;
      last_owner     <= OWN_INSTR;
      core_cyc       <= 1'b0;
      core_we        <= 1'b0;
      core_wstrb     <= '0;
      core_addr      <= '0;
      core_data_out  <= '0;
      instr_rvalid_o <= 1'b0;
      instr_err_o    <= 1'b0;
      instr_rdata_o  <= '0;
      data_rvalid_o  <= 1'b0;
      data_err_o     <= 1'b0;
      data_rdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= winner;
            core_cyc <= 1'b1;
            if (winner == OWN_DATA) begin
              core_addr     <= data_addr_i;
              core_we       <= data_we_i;
              core_wstrb    <= data_be_i;
              core_data_out <= data_wdata_i;
            end else begin
              core_addr     <= instr_addr_i;
              core_we       <= 1'b0;
              core_wstrb    <= '1;
              core_data_out <= '0;
            end
          end
        end
        BUS: begin
          // rvalid is raised on the ack edge so it is high during RESP.
          if (bus_done) begin
            core_cyc <= 1'b0;
            if (owner == OWN_DATA) begin
              data_rvalid_o <= 1'b1;
              data_err_o    <= bus_timeout;
              data_rdata_o  <= bus_timeout ? '0 : core_data_in;
            end else begin
              instr_rvalid_o <= 1'b1;
              instr_err_o    <= bus_timeout;
              instr_rdata_o  <= bus_timeout ? '0 : core_data_in;
            end
          end
        end
        RESP: begin
          instr_rvalid_o <= 1'b0;
          instr_err_o    <= 1'b0;
          data_rvalid_o  <= 1'b0;
          data_err_o     <= 1'b0;
          last_owner     <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule
